// File: rtl/wb_mem_pkg.sv
// Shared Wishbone memory definitions: cycle/burst type codes and the slave FSM state type.
package wb_mem_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StErr
  } wb_state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next burst word address: linear increment, or wrap inside the aligned 4/8/16-word block.
module wb_burst_addr_gen
  import wb_mem_pkg::*;
#(
  parameter int unsigned AddrW = 8
) (
  input  logic [AddrW-1:0] addr_i,
  input  logic [1:0]       bte_i,
  output logic [AddrW-1:0] next_o
);

  logic [AddrW-1:0] mask;
  logic [AddrW-1:0] incr;

  always_comb begin
    unique case (bte_i)
      BTE_WRAP4:  mask = AddrW'(3);
      BTE_WRAP8:  mask = AddrW'(7);
      BTE_WRAP16: mask = AddrW'(15);
      default:    mask = '1;
    endcase
    incr   = addr_i + AddrW'(1);
    // Upper bits stay fixed, only the bits inside the wrap block take the increment.
    next_o = (addr_i & ~mask) | (incr & mask);
  end

endmodule

// File: rtl/wb_burst_mem.sv
// Wishbone B3 slave RAM with byte selects, wait states and out-of-range ERR.
// Registered-feedback bursts are built only when WB_BURST_MEM_BURST_EN is defined.
module wb_burst_mem
  import wb_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                CYC_I,
  input  logic                STB_I,
  input  logic                WE_I,
  input  logic [ADDR_W-1:0]   ADR_I,
  input  logic [DATA_W/8-1:0] SEL_I,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic [2:0]          CTI_I,
  input  logic [1:0]          BTE_I,
  output logic [DATA_W-1:0]   DAT_O,
  output logic                ACK_O,
  output logic                ERR_O
);

  localparam int unsigned     SelW     = DATA_W / 8;
  localparam logic [ADDR_W:0] DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  wb_state_e         state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_q, err_q;
  logic [DATA_W-1:0] dat_q;

  logic              req;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;

  assign req = CYC_I & STB_I;

`ifdef WB_BURST_MEM_BURST_EN
  logic [ADDR_W-1:0] next_addr;
  logic              next_oor;

  wb_burst_addr_gen #(
    .AddrW (ADDR_W)
  ) u_addr_gen (
    .addr_i (addr_q),
    .bte_i  (BTE_I),
    .next_o (next_addr)
  );

  // Linear bursts test the carry so the last word of a full 2**ADDR_W map cannot alias to 0.
  assign next_oor = (BTE_I == BTE_LINEAR) ?
                    (({1'b0, addr_q} + (ADDR_W + 1)'(1)) >= DepthW) :
                    ({1'b0, next_addr} >= DepthW);
`else
  logic unused_burst;
  assign unused_burst = ^{CTI_I, BTE_I};
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = ADR_I;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if ({1'b0, ADR_I} >= DepthW) begin
            state_d = StErr;
          end else if (WAIT_STATES == 0) begin
            state_d = StAck;
            addr_d  = ADR_I;
            rd_en   = ~WE_I;
          end else begin
            state_d = StWait;
            wcnt_d  = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (wcnt_q == 4'd0) begin
          state_d = StAck;
          addr_d  = ADR_I;
          rd_en   = ~WE_I;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StAck: begin
        wr_en   = req & WE_I;
        state_d = StIdle;
`ifdef WB_BURST_MEM_BURST_EN
        if (req && CTI_I == CTI_INCR) begin
          if (next_oor) begin
            state_d = StErr;
          end else begin
            state_d = StAck;
            addr_d  = next_addr;
            rd_en   = ~WE_I;
            rd_addr = next_addr;
          end
        end
`endif
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      ack_q   <= (state_d == StAck);
      err_q   <= (state_d == StErr);
      if (rd_en) begin
        dat_q <= mem_q[rd_addr];
      end
    end
  end

  // Writes land on the edge that sees ACK_O with the request still held, at the beat address.
  always_ff @(posedge CLK_I) begin
    if (wr_en && !RST_I) begin
      for (int b = 0; b < SelW; b++) begin
        if (SEL_I[b]) begin
          mem_q[addr_q][8*b +: 8] <= DAT_I[8*b +: 8];
        end
      end
    end
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;

endmodule

// File: doc/wb_burst_mem.md
Name: wb_burst_mem

Overview:
Parametrised Wishbone B3 slave memory and the successor of the fixed 8-word, 32-bit classic-cycle memory. Generalised in data width, address width and depth. Adds byte selects, programmable wait states, an error response for out-of-range addresses, and optional registered-feedback burst cycles. Sits on the shared Wishbone bus as a scratch or data RAM behind the interconnect.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8.
ADDR_W, 8, word-address width.
DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
WAIT_STATES, 0, extra cycles before the first ACK_O of each cycle; range 0..15.

Ports:
CLK_I  in  1  single clock; all logic on rising edge.
RST_I  in  1  reset; synchronous, active-high.
CYC_I  in  1  bus cycle valid.
STB_I  in  1  strobe.
WE_I  in  1  1 = write, 0 = read.
ADR_I  in  ADDR_W  word address.
SEL_I  in  DATA_W/8  byte-lane enables; SEL_I[n] covers DAT bits 8n+7:8n.
DAT_I  in  DATA_W  write data.
CTI_I  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
BTE_I  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
DAT_O  out  DATA_W  read data.
ACK_O  out  1  normal termination.
ERR_O  out  1  error termination.

Behaviour:
- Reset, when RST_I is high at an edge: ACK_O=0, ERR_O=0, DAT_O=0, FSM=IDLE, wait counter=0, burst counter=0. Memory contents are not reset.
- Reset mid-cycle: any transfer not yet acked is aborted. No write occurs on the reset edge.
- Request is defined as CYC_I & STB_I.
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE -> request with ADR_I >= DEPTH -> ERR.
- IDLE -> request, WAIT_STATES=0 -> ACK.
- IDLE -> request, WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
- WAIT -> count down, then ACK. A request dropped during WAIT returns the FSM to IDLE with no ACK_O.
- Latency: ACK_O rises WAIT_STATES+1 cycles after the edge that first samples the request.
- ACK_O and ERR_O are registered, one-hot, and never both high.
- Read: DAT_O <= mem[addr] on the edge that raises ACK_O. DAT_O is held unchanged at all other times.
- Write: on an edge where ACK_O=1 and the request and WE_I are present, lanes with SEL_I=1 are written. SEL_I=0 leaves the word unchanged.
- Classic cycle (CTI_I=000 or feature off): ACK_O is high for exactly one cycle, then the FSM returns to IDLE for at least one cycle. The same strobe is never acked twice. A classic access therefore takes at least WAIT_STATES+2 cycles.
- ERR: ERR_O is high for one cycle, then IDLE. No write occurs and DAT_O is unchanged.
- Address is a word index and is never byte-shifted.

Optional Feature:
WB_BURST_MEM_BURST_EN.
- Defined: CTI_I=010 sampled with ACK_O high keeps the FSM in ACK. One beat completes per cycle, with no wait states after the first beat.
- An internal burst address is loaded from ADR_I on the first beat. Each later beat advances it: +1 for linear, wrap within the aligned 4/8/16-word block for the wrap types. Later-beat ADR_I is ignored.
- Read data for the next beat is prefetched from the next address.
- A beat with CTI_I=111, or the request dropping, ends the burst and the FSM returns to IDLE.
- A linear burst reaching DEPTH terminates that beat with ERR_O.
- Undefined: CTI_I and BTE_I are ignored and every access is classic. The ports remain.

Decomposition:
- Package wb_mem_pkg holds:
  - the CTI constants CTI_CLASSIC, CTI_INCR, CTI_EOB;
  - the BTE constants BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16;
  - the FSM state enum.
- One sub-module, wb_burst_addr_gen: combinational next-address computation from the current address, BTE and ADDR_W.

Test Plan:
- Reset then a classic write of addr 3 = 0xDEADBEEF with SEL=1111, then a read of addr 3 -> ACK_O one cycle each, DAT_O=0xDEADBEEF.
- Write addr 5 = 0x11223344, then write 0xAABBCCDD with SEL=0101, then read -> DAT_O=0x11BB33DD.
- WAIT_STATES=3, read -> ACK_O rises exactly 4 cycles after the request. Dropping STB_I in cycle 2 -> no ACK_O.
- DEPTH=200, access addr 250 -> ERR_O one cycle, no ACK_O, memory unchanged, DAT_O held.
- Feature on: wrap-4 burst read starting at addr 6 with 4 beats and the last beat CTI=111 -> 4 consecutive ACK_O cycles with data from addrs 6, 7, 4, 5.
- RST_I asserted during WAIT of a write -> ACK_O=0, target word unchanged, FSM back in IDLE.
